// File: rtl/fb_write_arbiter_if.sv
// rtl/fb_write_arbiter_if.sv - requester and framebuffer-write signal bundle for fb_write_arbiter
interface fb_write_arbiter_if #(
    parameter int NREQ      = 4,
    parameter int ADDR_BITS = 20
);
    // Requester side: one valid/last/addr/data lane per requester, packed by index
    logic [NREQ-1:0]           req_valid_i;
    logic [NREQ-1:0]           req_last_i;
    logic [NREQ*ADDR_BITS-1:0] req_addr_i;
    logic [NREQ*24-1:0]        req_data_i;
    logic [NREQ-1:0]           req_ready_o;

    // Framebuffer write side plus arbitration status
    logic [ADDR_BITS-1:0]      pxl_addr_o;
    logic [23:0]               pxl_data_o;
    logic                      pxl_en_o;
    logic [NREQ-1:0]           grant_o;
    logic [15:0]               drop_cnt_o;

    // Drives requests and observes the write port (requesters / bench)
    modport master (
        output req_valid_i, req_last_i, req_addr_i, req_data_i,
        input  req_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o, grant_o, drop_cnt_o
    );

    // The arbiter itself
    modport slave (
        input  req_valid_i, req_last_i, req_addr_i, req_data_i,
        output req_ready_o, pxl_addr_o, pxl_data_o, pxl_en_o, grant_o, drop_cnt_o
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin burst arbiter for framebuffer pixel writes (optional FB_ARB_BOUNDS_CHECK_EN)
module fb_write_arbiter #(
    parameter int NREQ = 4,
    parameter int FB_X = 1280,
    parameter int FB_Y = 720
) (
    input logic               clk_i,
    input logic               rst_i,
    fb_write_arbiter_if.slave bus
);
    localparam int PIXELS    = FB_X * FB_Y;
    localparam int ADDR_BITS = $clog2(PIXELS);
    localparam int PTR_W     = $clog2(NREQ);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     owner_q;
    logic                 pxl_en_q;
    logic [ADDR_BITS-1:0] pxl_addr_q;
    logic [23:0]          pxl_data_q;
    logic [15:0]          drop_cnt_q;

    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     sel_idx;
    logic [NREQ-1:0]      ready;
    logic                 accept;
    logic                 acc_last;
    logic [ADDR_BITS-1:0] acc_addr;
    logic [23:0]          acc_data;
    logic                 acc_oob;

    // Round-robin search starting just after the last requester served
    always_comb begin : winner_search
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && bus.req_valid_i[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    // One-hot ready: the burst owner while bursting, else the round-robin winner
    always_comb begin
        ready = '0;
        if (!rst_i) begin
            if (state_q == ST_BURST) begin
                ready[owner_q] = 1'b1;
            end else if (win_found) begin
                ready[win_idx] = 1'b1;
            end
        end
    end

    assign sel_idx  = (state_q == ST_BURST) ? owner_q : win_idx;
    assign accept   = |(ready & bus.req_valid_i);
    assign acc_last = bus.req_last_i[sel_idx];
    assign acc_addr = bus.req_addr_i[sel_idx*ADDR_BITS +: ADDR_BITS];
    assign acc_data = bus.req_data_i[sel_idx*24 +: 24];

`ifdef FB_ARB_BOUNDS_CHECK_EN
    // Beats past the end of the framebuffer are consumed but never written
    assign acc_oob = (32'(acc_addr) >= 32'(PIXELS));

    // Saturating count of discarded out-of-range beats
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (accept && acc_oob && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`else
    assign acc_oob = 1'b0;

    // No filtering: the drop counter stays at zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= '0;
        end
    end
`endif

    // Arbitration FSM plus the registered write port (one-cycle accept-to-write latency)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_W'(NREQ - 1);
            owner_q    <= '0;
            pxl_en_q   <= 1'b0;
            pxl_addr_q <= '0;
            pxl_data_q <= '0;
        end else begin
            pxl_en_q <= accept && !acc_oob;
            if (accept && !acc_oob) begin
                pxl_addr_q <= acc_addr;
                pxl_data_q <= acc_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (acc_last) begin
                            ptr_q <= win_idx;
                        end else begin
                            owner_q <= win_idx;
                            state_q <= ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (accept && acc_last) begin
                        ptr_q   <= owner_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.grant_o     = ready;
    assign bus.pxl_en_o    = pxl_en_q;
    assign bus.pxl_addr_o  = pxl_addr_q;
    assign bus.pxl_data_o  = pxl_data_q;
    assign bus.drop_cnt_o  = drop_cnt_q;
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of pixel-write requesters, 2..8.
REQ-002 Parameter FB_X, default 1280: framebuffer width in pixels.
REQ-003 Parameter FB_Y, default 720: framebuffer height in pixels.
REQ-004 Localparam PIXELS = FB_X*FB_Y; localparam ADDR_BITS = $clog2(PIXELS).
REQ-005 clk_i  input  1  single clock for all logic; only clock.
REQ-006 rst_i  input  1  reset, asynchronous, active-high.
REQ-007 req_valid_i  input  NREQ  per-requester beat valid.
REQ-008 req_last_i  input  NREQ  per-requester marker for the final beat of a burst.
REQ-009 req_addr_i  input  NREQ*ADDR_BITS  packed addresses; requester k occupies slice [k*ADDR_BITS +: ADDR_BITS].
REQ-010 req_data_i  input  NREQ*24  packed RGB888 data; requester k occupies slice [k*24 +: 24].
REQ-011 req_ready_o  output  NREQ  per-requester beat accept.
REQ-012 pxl_addr_o  output  ADDR_BITS  framebuffer write address.
REQ-013 pxl_data_o  output  24  framebuffer write data.
REQ-014 pxl_en_o  output  1  framebuffer write strobe, one write per high cycle.
REQ-015 grant_o  output  NREQ  one-hot current owner; all-zero when idle.
REQ-016 drop_cnt_o  output  16  count of discarded out-of-range beats.

Function
REQ-017 A beat from requester k is accepted in a cycle where req_valid_i[k] and req_ready_o[k] are both high.
REQ-018 At most one req_ready_o bit is high per cycle; req_ready_o is combinational from state, ptr and req_valid_i.
REQ-019 FSM states: IDLE and BURST.
REQ-020 IDLE: winner = first k with req_valid_i[k] high, searching ptr+1, ptr+2, ... modulo NREQ; req_ready_o[winner] is high in the same cycle.
REQ-021 IDLE, accepted beat with req_last_i high: remain IDLE, ptr <= winner.
REQ-022 IDLE, accepted beat with req_last_i low: go to BURST, owner <= winner.
REQ-023 IDLE with no valid requester: no accept, ptr unchanged, grant_o = 0.
REQ-024 BURST: req_ready_o[owner] = 1, all other bits 0, other requesters' valids ignored; grant_o = onehot(owner).
REQ-025 BURST with owner's valid low: hold state indefinitely, no timeout.
REQ-026 BURST, accepted beat with req_last_i high: go to IDLE, ptr <= owner.
REQ-027 grant_o in IDLE = onehot(winner) during an accept cycle, else 0.
REQ-028 Latency: an accepted beat appears on pxl_addr_o/pxl_data_o with pxl_en_o = 1 exactly 1 cycle later (registered outputs).
REQ-029 pxl_en_o is 0 in any cycle not following an accepted, non-dropped beat; pxl_addr_o/pxl_data_o hold their last values when pxl_en_o = 0.
REQ-030 Back-to-back accepts give pxl_en_o high on consecutive cycles; sustained throughput is 1 beat/cycle.
REQ-031 req_last_i on a non-accepted cycle has no effect.

Reset
REQ-032 On rst_i high, asynchronously: state = IDLE, ptr = NREQ-1 (requester 0 has first priority), owner = 0, pxl_en_o = 0, pxl_addr_o = 0, pxl_data_o = 0, drop_cnt_o = 0.
REQ-033 Reset asserted mid-burst aborts the burst; the output register for the in-flight beat is cleared and no write is issued.
REQ-034 While rst_i is high, req_ready_o = 0 and grant_o = 0.

Configuration
REQ-035 Macro FB_ARB_BOUNDS_CHECK_EN controls out-of-range address filtering.
REQ-036 Defined: an accepted beat with address >= PIXELS is consumed but not written (pxl_en_o stays 0 the next cycle); drop_cnt_o increments by 1 and saturates at 16'hFFFF; arbitration and FSM treat it as a normal beat, including req_last_i.
REQ-037 Undefined: no address check; every accepted beat is written; drop_cnt_o is tied to 0.

Verification
REQ-038 After reset, requesters 0..3 all single-beat valid (last = 1) continuously -> grants cycle 0,1,2,3,0, one per cycle; pxl_en_o high every cycle from cycle 2 on.
REQ-039 Requester 2 sends 4 beats, addr 100..103, last on beat 4, while requester 1 is valid -> req_ready_o[1] = 0 through the burst; writes 100..103 in order; requester 1 is granted next.
REQ-040 During requester 0's burst, req_valid_i[0] is dropped for 3 cycles -> FSM stays BURST, grant_o = 4'b0001, no pxl_en_o pulses, then resumes.
REQ-041 rst_i pulsed after the second beat of a 5-beat burst -> pxl_en_o = 0 immediately, FSM IDLE, requester 0 has priority after release.
REQ-042 With FB_ARB_BOUNDS_CHECK_EN, beats at addr PIXELS and PIXELS-1 -> only PIXELS-1 is written; drop_cnt_o = 1. Without the macro, both beats are written and drop_cnt_o = 0.
